// File: rtl/modn_up_counter_pkg.sv
// counter_pkg: constants and sizing helper shared by the modulo-N counter files
package counter_pkg;
  localparam logic [7:0] WRAP_MAX = 8'd255;
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction
endpackage

// File: rtl/modn_up_counter_if.sv
// modn_up_counter_if: control inputs and count/status outputs of one counter
interface modn_up_counter_if #(parameter int WIDTH = 3) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             carry;
  logic [7:0]       wrap_cnt;
  logic             load_err;
  modport master (output en, load, d, input q, tc, carry, wrap_cnt, load_err);
  modport slave  (input en, load, d, output q, tc, carry, wrap_cnt, load_err);
endinterface

// File: rtl/modn_up_counter_prescaler.sv
// tick_prescaler: emits one tick every PRESCALE enabled cycles; clr restarts the phase
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] phase;
  assign tick = en && (phase == LAST);
  // phase advances only on enabled cycles and wraps after the tick
  always_ff @(posedge clk or posedge rst)
    if (rst) phase <= '0;
    else if (clr) phase <= '0;
    else if (en) phase <= tick ? '0 : phase + PW'(1);
endmodule

// File: rtl/modn_up_counter.sv
// modn_up_counter: modulo-N up counter with load, prescaler, carry and saturating wrap count
module modn_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int PRESCALE = 1
) (
  input logic               clk,
  input logic               rst,
  modn_up_counter_if.slave  bus
);
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH || PRESCALE < 1 || PRESCALE > 256) begin : g_bad_param
    $error("modn_up_counter: illegal parameter set");
  end
  localparam logic [WIDTH:0]   MOD  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  logic             tick;
  logic             tc;
  logic             d_ok;
  logic [WIDTH-1:0] q;
  logic [7:0]       wrap_cnt;
  logic             load_err;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (tick)
  );
  assign d_ok         = {1'b0, bus.d} < MOD;
  assign tc           = q == LAST;
  assign bus.q        = q;
  assign bus.tc       = tc;
  assign bus.carry    = tc & tick & ~bus.load;
  assign bus.wrap_cnt = wrap_cnt;
  assign bus.load_err = load_err;
  // load beats tick; out-of-range loads clear q and latch the sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q        <= '0;
      wrap_cnt <= '0;
      load_err <= 1'b0;
    end else if (bus.load) begin
      q        <= d_ok ? bus.d : '0;
      wrap_cnt <= '0;
      if (!d_ok) load_err <= 1'b1;
    end else if (tick) begin
      q <= tc ? '0 : q + WIDTH'(1);
      if (tc && wrap_cnt != WRAP_MAX) wrap_cnt <= wrap_cnt + 8'd1;
    end
endmodule

// File: tb/tb_modn_up_counter.sv
// tb_modn_up_counter: directed checks of default, prescaled, mod-6 and cascaded counters
module tb_modn_up_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b1;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  modn_up_counter_if #(.WIDTH(3)) b0 ();
  modn_up_counter_if #(.WIDTH(3)) b1 ();
  modn_up_counter_if #(.WIDTH(3)) b2 ();
  modn_up_counter_if #(.WIDTH(3)) b3 ();
  modn_up_counter_if #(.WIDTH(3)) b4 ();
  modn_up_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  modn_up_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  modn_up_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  modn_up_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) dut_lo (.clk(clk), .rst(rst_c), .bus(b3));
  modn_up_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) dut_hi (.clk(clk), .rst(rst_c), .bus(b4));
  assign b4.en = b3.carry;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    {b0.en, b0.load, b0.d} = '0;
    {b1.en, b1.load, b1.d} = '0;
    {b2.en, b2.load, b2.d} = '0;
    {b3.en, b3.load, b3.d} = '0;
    {b4.load, b4.d} = '0;
    #12;
    rst = 1'b0;
    rst_c = 1'b0;
    chk("rst_q", 32'(b0.q), 0);
    chk("rst_tc", 32'(b0.tc), 0);
    chk("rst_carry", 32'(b0.carry), 0);
    chk("rst_wrap", 32'(b0.wrap_cnt), 0);
    chk("rst_err", 32'(b0.load_err), 0);
    b0.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("cnt_q", 32'(b0.q), i % 8);
      chk("cnt_tc", 32'(b0.tc), (i % 8 == 7) ? 1 : 0);
      chk("cnt_carry", 32'(b0.carry), (i % 8 == 7) ? 1 : 0);
      chk("cnt_wrap", 32'(b0.wrap_cnt), (i >= 8) ? 1 : 0);
      step(1);
    end
    chk("cnt_q_end", 32'(b0.q), 2);
    chk("cnt_wrap_end", 32'(b0.wrap_cnt), 1);
    step(2022);
    chk("sat_254", 32'(b0.wrap_cnt), 254);
    step(8);
    chk("sat_255", 32'(b0.wrap_cnt), 255);
    step(16);
    chk("sat_hold", 32'(b0.wrap_cnt), 255);
    chk("sat_q", 32'(b0.q), 0);
    step(5);
    chk("pre_load_q", 32'(b0.q), 5);
    b0.load = 1'b1;
    b0.d = 3'd2;
    step(1);
    b0.load = 1'b0;
    chk("load_q", 32'(b0.q), 2);
    chk("load_wrap", 32'(b0.wrap_cnt), 0);
    step(1);
    chk("after_load_q", 32'(b0.q), 3);
    step(4);
    chk("tc_q", 32'(b0.q), 7);
    chk("tc_carry", 32'(b0.carry), 1);
    b0.load = 1'b1;
    b0.d = 3'd0;
    #1;
    chk("load_kills_carry", 32'(b0.carry), 0);
    step(1);
    b0.load = 1'b0;
    chk("load_tc_q", 32'(b0.q), 0);
    chk("load_tc_wrap", 32'(b0.wrap_cnt), 0);
    chk("load_ok_err", 32'(b0.load_err), 0);
    b1.en = 1'b1;
    step(1);
    chk("ps_e1", 32'(b1.q), 0);
    step(1);
    chk("ps_e2", 32'(b1.q), 0);
    step(1);
    chk("ps_e3", 32'(b1.q), 1);
    step(1);
    b1.en = 1'b0;
    chk("ps_e4", 32'(b1.q), 1);
    step(2);
    chk("ps_frozen", 32'(b1.q), 1);
    b1.en = 1'b1;
    step(1);
    chk("ps_resume1", 32'(b1.q), 1);
    step(1);
    chk("ps_resume2", 32'(b1.q), 2);
    b2.load = 1'b1;
    b2.d = 3'd7;
    step(1);
    b2.load = 1'b0;
    chk("m6_bad_q", 32'(b2.q), 0);
    chk("m6_err", 32'(b2.load_err), 1);
    b2.en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("m6_q", 32'(b2.q), k % 6);
      chk("m6_tc", 32'(b2.tc), (k % 6 == 5) ? 1 : 0);
    end
    chk("m6_err_sticky", 32'(b2.load_err), 1);
    b2.load = 1'b1;
    b2.d = 3'd5;
    step(1);
    b2.load = 1'b0;
    chk("m6_good_load_q", 32'(b2.q), 5);
    chk("m6_err_still", 32'(b2.load_err), 1);
    b3.en = 1'b1;
    for (int n = 0; n < 84; n++) begin
      chk("casc", 32'({b4.q, b3.q}), n % 64);
      step(1);
    end
    chk("casc_20", 32'({b4.q, b3.q}), 20);
    chk("casc_hi_wrap", 32'(b4.wrap_cnt), 1);
    rst_c = 1'b1;
    #2;
    chk("casc_rst_lo", 32'(b3.q), 0);
    chk("casc_rst_hi", 32'(b4.q), 0);
    chk("casc_rst_wrap", 32'(b3.wrap_cnt), 0);
    #1;
    rst_c = 1'b0;
    step(1);
    chk("casc_resume", 32'({b4.q, b3.q}), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
